// File: rtl/aes_addroundkey_keysched_if.sv
// Handshake bundle for the AES AddRoundKey / key-schedule stage.
// Carries key load, upstream state and registered round output.
interface aes_addroundkey_keysched_if;
  logic         key_load;
  logic [127:0] key_in;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic [3:0]   out_round;
  logic         out_last;

  modport master (
    output key_load,
    output key_in,
    output in_valid,
    input  in_ready,
    output state_in,
    input  out_valid,
    output out_ready,
    input  state_out,
    input  out_round,
    input  out_last
  );

  modport slave (
    input  key_load,
    input  key_in,
    input  in_valid,
    output in_ready,
    input  state_in,
    output out_valid,
    input  out_ready,
    output state_out,
    output out_round,
    output out_last
  );
endinterface

// File: rtl/aes_addroundkey_keysched.sv
// AES-128 AddRoundKey stage with on-the-fly key expansion.
// One round key is consumed and the next derived per accepted state.
module aes_addroundkey_keysched #(
  parameter logic [127:0] RESET_KEY = 128'h0
) (
  input  logic                          clk,
  input  logic                          rst,
  aes_addroundkey_keysched_if.slave     bus
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b
      ^ {b[6:0], b[7]}
      ^ {b[5:0], b[7:6]}
      ^ {b[4:0], b[7:5]}
      ^ {b[3:0], b[7:4]}
      ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  logic [127:0] cipher_key_q, cipher_key_d;
  logic [127:0] round_key_q, round_key_d;
  logic [3:0]   round_q, round_d;
  logic         key_valid_q, key_valid_d;
  logic [127:0] state_out_q, state_out_d;
  logic [3:0]   out_round_q, out_round_d;
  logic         out_last_q, out_last_d;
  logic         out_valid_q, out_valid_d;

  logic         in_ready;
  logic         accept;
  logic         last_round;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot, sub, t;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_key;

  assign in_ready = key_valid_q
                  & (~out_valid_q | bus.out_ready)
                  & ~bus.key_load;
  assign accept     = bus.in_valid & in_ready;
  assign last_round = (round_q == 4'd10);

  always_comb begin
    w0  = round_key_q[127:96];
    w1  = round_key_q[95:64];
    w2  = round_key_q[63:32];
    w3  = round_key_q[31:0];
    rot = {w3[23:0], w3[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]),
           sbox(rot[15:8]),  sbox(rot[7:0])};
    t   = sub ^ {rcon(round_q + 4'd1), 24'h0};
    n0  = w0 ^ t;
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  always_comb begin
    cipher_key_d = cipher_key_q;
    round_key_d  = round_key_q;
    round_d      = round_q;
    key_valid_d  = key_valid_q;
    state_out_d  = state_out_q;
    out_round_d  = out_round_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q;
    // A fresh key aborts whatever block was in flight
    if (bus.key_load) begin
      cipher_key_d = bus.key_in;
      round_key_d  = bus.key_in;
      round_d      = 4'd0;
      key_valid_d  = 1'b1;
      out_valid_d  = 1'b0;
    end else if (accept) begin
      state_out_d = bus.state_in ^ round_key_q;
      out_round_d = round_q;
      out_last_d  = last_round;
      out_valid_d = 1'b1;
      if (last_round) begin
        round_key_d = cipher_key_q;
        round_d     = 4'd0;
      end else begin
        round_key_d = next_key;
        round_d     = round_q + 4'd1;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cipher_key_q <= RESET_KEY;
      round_key_q  <= RESET_KEY;
      round_q      <= 4'd0;
      key_valid_q  <= 1'b0;
      state_out_q  <= 128'h0;
      out_round_q  <= 4'd0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      cipher_key_q <= cipher_key_d;
      round_key_q  <= round_key_d;
      round_q      <= round_d;
      key_valid_q  <= key_valid_d;
      state_out_q  <= state_out_d;
      out_round_q  <= out_round_d;
      out_last_q   <= out_last_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.state_out = state_out_q;
  assign bus.out_round = out_round_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: doc/aes_addroundkey_keysched.md
Name: aes_addroundkey_keysched

Overview:
Downstream neighbour of the MixColumns stage in the AES-128 encryption datapath. Consumes the 128-bit state from MixColumns, or from the initial/final-round bypass, and XORs it with the current round key. The round key is expanded on the fly, one round per accepted state, from the loaded cipher key. Registered output with valid/ready handshake, so the block also serves as the round pipeline register.

Parameters:
RESET_KEY, 128'h0, cipher-key register value after reset (key_valid still 0)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
key_load  input  1  load key_in as cipher key; single-cycle pulse, always accepted
key_in  input  128  AES-128 cipher key; byte 0 at [127:120], word w0 = [127:96]
in_valid  input  1  state_in valid
in_ready  output  1  block accepts state_in this cycle
state_in  input  128  state from MixColumns or bypass; column-major, byte 0 at [127:120]
out_valid  output  1  state_out valid
out_ready  input  1  consumer accepts state_out
state_out  output  128  state_in XOR round key
out_round  output  4  round index 0..10 of the key applied to state_out
out_last  output  1  high with state_out when out_round == 10

Behaviour:
- Reset (rst=1 at edge):
  - key_valid=0, round=0, out_valid=0, state_out=0, out_round=0, out_last=0.
  - cipher_key and round_key both set to RESET_KEY.
  - in_ready=0 while key_valid=0.
- Registers:
  - cipher_key[127:0], round_key[127:0], round[3:0] (0..10), key_valid.
  - Output register state_out/out_round/out_last/out_valid.
- in_ready = key_valid & (!out_valid | out_ready); combinational, no skid buffer.
- Accept = in_valid & in_ready. On accept, at the next edge:
  - state_out = state_in ^ round_key; out_round = round; out_last = (round==10); out_valid=1.
  - If round<10: round_key = expand(round_key, rcon[round+1]); round += 1.
  - If round==10: round_key = cipher_key; round = 0, ready for the next block.
- Output hold:
  - If out_valid & !out_ready and no accept, all output registers hold.
  - If out_ready & !accept, out_valid clears.
  - Throughput is one state per cycle when out_ready is held high.
- expand(): words w0..w3 = round_key[127:96]..[31:0].
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}, where RotWord rotates left by one byte.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- SubWord: four parallel combinational AES S-boxes, computed as GF(2^8) inverse (poly 0x11B, inv(0)=0) followed by affine transform with constant 0x63.
- Key load (key_load=1 at edge), overrides everything except rst:
  - cipher_key = round_key = key_in; round=0; key_valid=1.
  - out_valid cleared; any in-flight block is aborted.
  - in_ready is forced 0 in the key_load cycle, so no accept that cycle.
- rst has priority over key_load. Reset mid-block discards the partial block and the key.
- round never exceeds 10. Wrap from 10 to 0 restores cipher_key and performs no expansion.
- Upstream owns the MixColumns bypass for round 0 and round 10. This block only sequences keys and counts accepted states.

Test Plan:
- Reset then key_in=2b7e151628aed2a6abf7158809cf4f3c, key_load pulse; state_in=3243f6a8885a308d313198a2e0370734 -> next cycle state_out=193de3bea0f4e22b9ac68d2ae9f84808, out_round=0, out_last=0.
- Continue with state_in=046681e5e0cb199a48f8d37a2806264c -> state_out=a49c7ff2689f352b6b5bea43026a5049, out_round=1.
- Feed 11 states of all-zero with out_ready=1 -> state_out sequence equals round keys.
  - Round 1: a0fafe1788542cb123a339392a6c7605.
  - Round 10: d014f9a8c9ee2589e13f0cc8b6630ca6, with out_last=1.
  - A 12th state yields 2b7e151628aed2a6abf7158809cf4f3c at out_round=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> first output held stable, in_ready=0, round advances only once; release -> one output per cycle, no loss or duplicate.
- Before any key_load after rst -> in_ready=0 for 20 cycles with in_valid=1; out_valid stays 0.
- key_load at round 5 with out_valid=1 -> out_valid=0 next cycle; next accepted state uses the new key with out_round=0.
- rst at round 7 -> all outputs 0, in_ready=0 until the next key_load.
